ex_forwarding_tracker: RTL and testbench
========================================

// Module: ex_forwarding_tracker
// PURPOSE
// - Forwarding-control (Unidad de Cortocircuito) for the 5-stage MIPS pipeline; drives the 3-bit selects of the EX operand muxes.
// - Keeps its own shadow pipeline of dest-reg/control (EX, EX/MEM, MEM/WB), compares against rs/rt of the instruction in ID,
//   and registers the selects so they are valid for the whole cycle that instruction sits in EX.
// - Also detects load-use hazards and requests a one-cycle stall of PC/IF-ID.
// PARAMETERS
// - NBITS_REG      5  register-address width
// - CORTOCIRCUITO  3  width of each forwarding select
// PORTS
// - i_clk           in   1              pipeline clock, rising edge
// - i_reset         in   1              asynchronous, active-high reset
// - i_stall         in   1              global freeze (debug step); holds all state
// - i_flush         in   1              inject bubble into EX (branch/jump taken)
// - i_ID_valid      in   1              ID holds a real instruction
// - i_ID_rs         in   NBITS_REG      source A address of instruction in ID
// - i_ID_rt         in   NBITS_REG      source B address of instruction in ID
// - i_ID_rd         in   NBITS_REG      destination address (already rt/rd/31-muxed)
// - i_ID_RegWrite   in   1              instruction in ID writes the register file
// - i_ID_MemRead    in   1              instruction in ID is a load
// - o_EX_CortoA     out  CORTOCIRCUITO  select for operand A mux (registered)
// - o_EX_CortoB     out  CORTOCIRCUITO  select for operand B mux (registered)
// - o_hazard_stall  out  1              load-use stall request (combinational)
// BEHAVIOUR
// - State: three slots EX, MEM, WB; each {valid, rd, RegWrite, MemRead}. Reset (async): all slots 0, o_EX_CortoA/B = 3'b000.
// - Advance (edge with i_stall=0): WB<=MEM, MEM<=EX, EX<=ID entry or bubble; selects load with the ID entry.
// - Bubble (all slot fields 0, selects 3'b000) on i_flush=1 or o_hazard_stall=1.
// - Priority: i_reset > i_stall (hold all, incl. selects) > i_flush > hazard bubble > normal.
// - Select per source S in {rs,rt} (from pre-edge state):
//   - 3'b001 if EX.valid & EX.RegWrite & EX.rd==S & S!=0 (producer is in EX/MEM when consumer is in EX);
//   - else 3'b010 if MEM.valid & MEM.RegWrite & MEM.rd==S & S!=0 (producer is in MEM/WB);
//   - else 3'b000. 001 beats 010 when both match (youngest value wins).
//   - Encodings 011..111 are never produced.
// - Register $0 is never forwarded, even if an instruction targets it.
// - Load-use: o_hazard_stall = i_ID_valid & EX.valid & EX.MemRead & EX.rd!=0 & (EX.rd==i_ID_rs | EX.rd==i_ID_rt).
//   - Purely combinational; asserted for exactly one cycle per hazard, because the load leaves EX next edge.
//   - After the bubble the consumer gets 3'b010 (load in MEM/WB).
//   - Forced 0 while i_flush=1 (ID instruction is discarded).
// - WB slot is kept only for the FWD_STATS_EN bookkeeping/observability; reads past MEM/WB go through the register file (write-first).
// - Reset asserted mid-stream: all slots cleared immediately; the first edge after release starts from an empty pipeline.
// - Latency: selects valid 1 edge after ID entry; stall request 0 cycles.
// CONFIGURATION
// - FWD_STATS_EN defined: adds outputs o_fwd_count[15:0] and o_stall_count[15:0], reset to 0.
//   - o_fwd_count: +1 per advancing edge where any non-zero select is loaded (A and B together count once).
//   - o_stall_count: +1 per cycle with o_hazard_stall=1 and i_stall=0.
//   - Both saturate at 16'hFFFF; both hold while i_stall=1.
// - FWD_STATS_EN undefined: no counters, ports absent; behaviour otherwise identical.
// TESTING
// - add $3,$1,$2 then sub $4,$3,$5 back-to-back -> sub in EX: CortoA=001, CortoB=000.
// - add $3 ; nop ; or $6,$7,$3 -> or in EX: CortoA=000, CortoB=010.
// - add $3 ; add $3 ; and $8,$3,$3 -> CortoA=CortoB=001 (youngest wins).
// - lw $9,0($1) then add $10,$9,$2 -> o_hazard_stall=1 one cycle, bubble selects 000, then add gets CortoA=010; stall_count=1.
// - addi $0,$1,5 then add $2,$0,$0 -> selects 000, no stall; i_flush with lw in EX and dependent in ID -> o_hazard_stall=0.
// - i_stall held 3 cycles mid-dependency -> selects/slots unchanged; i_reset pulse mid-stream -> selects 000, counters 0 at once.

Source files
------------

// File: rtl/ex_forwarding_tracker.sv
// EX operand forwarding selects and load-use stall detection for the 5-stage MIPS pipeline.
// Optional counters: define FWD_STATS_EN.
module ex_forwarding_tracker #(
  parameter int NBITS_REG     = 5,
  parameter int CORTOCIRCUITO = 3
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_stall,
  input  logic                     i_flush,
  input  logic                     i_ID_valid,
  input  logic [NBITS_REG-1:0]     i_ID_rs,
  input  logic [NBITS_REG-1:0]     i_ID_rt,
  input  logic [NBITS_REG-1:0]     i_ID_rd,
  input  logic                     i_ID_RegWrite,
  input  logic                     i_ID_MemRead,
  output logic [CORTOCIRCUITO-1:0] o_EX_CortoA,
  output logic [CORTOCIRCUITO-1:0] o_EX_CortoB,
`ifdef FWD_STATS_EN
  output logic [15:0]              o_fwd_count,
  output logic [15:0]              o_stall_count,
`endif
  output logic                     o_hazard_stall
);

  typedef struct packed {
    logic                 valid;
    logic [NBITS_REG-1:0] rd;
    logic                 reg_write;
    logic                 mem_read;
  } slot_t;

  localparam logic [CORTOCIRCUITO-1:0] SEL_NONE  = '0;
  localparam logic [CORTOCIRCUITO-1:0] SEL_EXMEM = CORTOCIRCUITO'(1);
  localparam logic [CORTOCIRCUITO-1:0] SEL_MEMWB = CORTOCIRCUITO'(2);
  localparam logic [NBITS_REG-1:0]     REG_ZERO  = '0;

  slot_t ex_q;
  slot_t mem_q;
  slot_t wb_q;
  slot_t id_slot;
  slot_t ex_d;

  logic                     bubble;
  logic                     ld_hit;
  logic [CORTOCIRCUITO-1:0] sel_a_d;
  logic [CORTOCIRCUITO-1:0] sel_b_d;

  // WB slot is observability only; nothing downstream consumes it.
  logic wb_unused;
  assign wb_unused = ^wb_q;

  function automatic logic [CORTOCIRCUITO-1:0] pick(
    input logic [NBITS_REG-1:0] src,
    input slot_t                ex,
    input slot_t                mem
  );
    logic ex_hit;
    logic mem_hit;
    logic [CORTOCIRCUITO-1:0] sel;
    ex_hit  = ex.valid & ex.reg_write
            & (ex.rd == src) & (src != REG_ZERO);
    mem_hit = mem.valid & mem.reg_write
            & (mem.rd == src) & (src != REG_ZERO);
    sel = SEL_NONE;
    unique case (1'b1)
      ex_hit:             sel = SEL_EXMEM;
      !ex_hit && mem_hit: sel = SEL_MEMWB;
      default:            sel = SEL_NONE;
    endcase
    return sel;
  endfunction

  always_comb begin
    ld_hit = ex_q.valid & ex_q.mem_read
           & (ex_q.rd != REG_ZERO)
           & ((ex_q.rd == i_ID_rs) | (ex_q.rd == i_ID_rt));
    o_hazard_stall = i_ID_valid & ld_hit & ~i_flush;
  end

  always_comb begin
    id_slot.valid     = i_ID_valid;
    id_slot.rd        = i_ID_rd;
    id_slot.reg_write = i_ID_RegWrite;
    id_slot.mem_read  = i_ID_MemRead;
    bubble  = i_flush | o_hazard_stall;
    ex_d    = id_slot;
    sel_a_d = pick(i_ID_rs, ex_q, mem_q);
    sel_b_d = pick(i_ID_rt, ex_q, mem_q);
    if (bubble) begin
      ex_d    = '0;
      sel_a_d = SEL_NONE;
      sel_b_d = SEL_NONE;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      ex_q        <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      o_EX_CortoA <= SEL_NONE;
      o_EX_CortoB <= SEL_NONE;
    end else if (!i_stall) begin
      wb_q        <= mem_q;
      mem_q       <= ex_q;
      ex_q        <= ex_d;
      o_EX_CortoA <= sel_a_d;
      o_EX_CortoB <= sel_b_d;
    end
  end

`ifdef FWD_STATS_EN
  logic fwd_evt;
  logic stall_evt;

  assign fwd_evt   = ~i_stall & ((sel_a_d != SEL_NONE) | (sel_b_d != SEL_NONE));
  assign stall_evt = ~i_stall & o_hazard_stall;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_fwd_count   <= '0;
      o_stall_count <= '0;
    end else begin
      if (fwd_evt && o_fwd_count != 16'hFFFF)
        o_fwd_count <= o_fwd_count + 16'd1;
      if (stall_evt && o_stall_count != 16'hFFFF)
        o_stall_count <= o_stall_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ex_forwarding_tracker.sv
// Directed vector bench for ex_forwarding_tracker.
// Counter checks are active when FWD_STATS_EN is defined.
module tb_ex_forwarding_tracker;

  logic       clk;
  logic       rst;
  logic       stall;
  logic       flush;
  logic       id_valid;
  logic [4:0] rs;
  logic [4:0] rt;
  logic [4:0] rd;
  logic       rw;
  logic       mr;
  logic [2:0] cor_a;
  logic [2:0] cor_b;
  logic       hz;
`ifdef FWD_STATS_EN
  logic [15:0] fwd_cnt;
  logic [15:0] stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  ex_forwarding_tracker dut (
    .i_clk         (clk),
    .i_reset       (rst),
    .i_stall       (stall),
    .i_flush       (flush),
    .i_ID_valid    (id_valid),
    .i_ID_rs       (rs),
    .i_ID_rt       (rt),
    .i_ID_rd       (rd),
    .i_ID_RegWrite (rw),
    .i_ID_MemRead  (mr),
    .o_EX_CortoA   (cor_a),
    .o_EX_CortoB   (cor_b),
`ifdef FWD_STATS_EN
    .o_fwd_count   (fwd_cnt),
    .o_stall_count (stall_cnt),
`endif
    .o_hazard_stall(hz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       stall;
    logic       flush;
    logic       valid;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic       rw;
    logic       mr;
    logic       hz;
    logic [2:0] a;
    logic [2:0] b;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string name, input logic [15:0] act,
                     input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    stall    = v.stall;
    flush    = v.flush;
    id_valid = v.valid;
    rs       = v.rs;
    rt       = v.rt;
    rd       = v.rd;
    rw       = v.rw;
    mr       = v.mr;
  endtask

  task automatic apply(input vec_t v, input int idx);
    @(negedge clk);
    drive(v);
    #1;
    chk($sformatf("v%0d_hz", idx), {15'd0, hz}, {15'd0, v.hz});
    @(posedge clk);
    #1;
    chk($sformatf("v%0d_A", idx), {13'd0, cor_a}, {13'd0, v.a});
    chk($sformatf("v%0d_B", idx), {13'd0, cor_b}, {13'd0, v.b});
  endtask

  initial begin
    // stall flush valid rs rt rd rw mr | hz A B
    vq.push_back('{0,0,1, 1, 2, 3,1,0, 0,0,0}); // add $3,$1,$2
    vq.push_back('{0,0,1, 3, 5, 4,1,0, 0,1,0}); // sub $4,$3,$5
    vq.push_back('{0,0,0, 0, 0, 0,0,0, 0,0,0}); // nop
    vq.push_back('{0,0,1, 1, 2, 3,1,0, 0,0,0}); // add $3
    vq.push_back('{0,0,0, 0, 0, 0,0,0, 0,0,0}); // nop
    vq.push_back('{0,0,1, 7, 3, 6,1,0, 0,0,2}); // or $6,$7,$3
    vq.push_back('{0,0,1, 1, 2, 3,1,0, 0,0,0}); // add $3
    vq.push_back('{0,0,1, 1, 2, 3,1,0, 0,0,0}); // add $3
    vq.push_back('{0,0,1, 3, 3, 8,1,0, 0,1,1}); // and $8,$3,$3
    vq.push_back('{0,0,1, 1, 0, 0,1,0, 0,0,0}); // addi $0,$1,5
    vq.push_back('{0,0,1, 0, 0, 2,1,0, 0,0,0}); // add $2,$0,$0
    vq.push_back('{0,0,1, 1, 9, 9,1,1, 0,0,0}); // lw $9,0($1)
    vq.push_back('{0,0,1, 9, 2,10,1,0, 1,0,0}); // add $10,$9,$2 stalls
    vq.push_back('{0,0,1, 9, 2,10,1,0, 0,2,0}); // add retried
    vq.push_back('{0,0,1, 1, 9, 9,1,1, 0,0,0}); // lw $9
    vq.push_back('{0,1,1, 9, 2,10,1,0, 0,0,0}); // flushed dependent
    vq.push_back('{0,0,1, 9, 9,11,1,0, 0,2,2}); // add $11,$9,$9
    vq.push_back('{0,0,1, 1, 2,12,1,0, 0,0,0}); // add $12
    vq.push_back('{1,0,1,12,11,13,1,0, 0,0,0}); // sub $13 frozen
    vq.push_back('{1,0,1,12,11,13,1,0, 0,0,0});
    vq.push_back('{1,0,1,12,11,13,1,0, 0,0,0});
    vq.push_back('{0,0,1,12,11,13,1,0, 0,1,2}); // released
    vq.push_back('{1,0,0, 0, 0, 0,0,0, 0,1,2}); // freeze holds selects
    vq.push_back('{0,0,0, 0, 0, 0,0,0, 0,0,0}); // nop
    vq.push_back('{0,0,1, 1, 2, 3,1,0, 0,0,0}); // add $3
    vq.push_back('{0,0,1, 3, 5, 4,1,0, 0,1,0}); // sub $4,$3,$5

    rst = 1'b1;
    drive('{0,0,0,0,0,0,0,0,0,0,0});
    repeat (2) @(posedge clk);
    #1;
    chk("reset_A", {13'd0, cor_a}, 16'd0);
    chk("reset_B", {13'd0, cor_b}, 16'd0);
    chk("reset_hz", {15'd0, hz}, 16'd0);
`ifdef FWD_STATS_EN
    chk("reset_fwd", fwd_cnt, 16'd0);
    chk("reset_stl", stall_cnt, 16'd0);
`endif
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vq.size(); i++)
      apply(vq[i], i);

`ifdef FWD_STATS_EN
    chk("fwd_count", fwd_cnt, 16'd7);
    chk("stall_count", stall_cnt, 16'd1);
`endif

    // Async reset mid-stream clears selects and counters at once
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_A", {13'd0, cor_a}, 16'd0);
    chk("midrst_B", {13'd0, cor_b}, 16'd0);
`ifdef FWD_STATS_EN
    chk("midrst_fwd", fwd_cnt, 16'd0);
    chk("midrst_stl", stall_cnt, 16'd0);
`endif
    #2;
    rst = 1'b0;
    // Producer was flushed by reset: consumer sees empty pipeline
    apply('{0,0,1, 3, 5, 4,1,0, 0,0,0}, 100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
